memory_bus_arbiter: RTL and testbench
=====================================

Name: memory_bus_arbiter

Overview:
- N-to-1 arbiter that lets NUM_MASTERS ray units share one memory-bus master port.
- Requests: round-robin, registered, with a per-master cap on outstanding reads.
- Responses: routed back to the issuing channel by smID.
- Sits between the array of ray units and the memory controller; this is the multi-channel generalisation of the single-unit flattened bus hookup.

Parameters:
NUM_MASTERS, 4, number of upstream request/response channels (1..16)
DATA_WIDTH, 24, bus data width
ADDRESS_WIDTH, 32, bus address width
MASTER_ID_WIDTH, 8, width of msID/smID
MASTER_ID_BASE, 5, ID of channel 0; channel i uses ID MASTER_ID_BASE+i
MAX_OUTSTANDING, 4, maximum reads in flight per channel (1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
upAddress  in  NUM_MASTERS*ADDRESS_WIDTH  per-channel request address
upData  in  NUM_MASTERS*DATA_WIDTH  per-channel write data
upWrite  in  NUM_MASTERS  1=write, 0=read
upValid  in  NUM_MASTERS  per-channel request valid
upTaken  out  NUM_MASTERS  per-channel request accepted
dnData  out  NUM_MASTERS*DATA_WIDTH  per-channel response data
dnValid  out  NUM_MASTERS  per-channel response valid
dnTaken  in  NUM_MASTERS  per-channel response accepted
msID  out  MASTER_ID_WIDTH  downstream request ID
msAddress  out  ADDRESS_WIDTH  downstream address
msData  out  DATA_WIDTH  downstream write data
msWrite  out  1  downstream write flag
msValid  out  1  downstream request valid
msTaken  in  1  downstream accept
smID  in  MASTER_ID_WIDTH  response ID
smData  in  DATA_WIDTH  response data
smValid  in  1  response valid
smTaken  out  1  response accepted
dropCount  out  8  saturating count of responses with unknown ID

Behaviour:
- Handshake on all channels: a transfer happens when valid && taken in the same cycle. A source holds valid and its payload stable until the transfer.
- Reset: msValid=0, msID/msAddress/msData/msWrite=0, round-robin pointer=0, all outstanding counters=0, dropCount=0. A reset mid-transfer discards the held request; any responses still in flight for it are subsequently dropped or counted as normal.
- Output register: holds one request.
  - "Load" occurs when msValid==0 or (msValid && msTaken).
- Eligibility of channel i: upValid[i] && (upWrite[i] || outstanding[i] < MAX_OUTSTANDING).
- Arbitration on load:
  - Search starts at the pointer and wraps modulo NUM_MASTERS; the first eligible channel g wins.
  - upTaken[g]=1 in that same cycle (combinational; every other upTaken bit is 0).
  - Next cycle: msValid=1, msID=MASTER_ID_BASE+g, and payload copied from channel g.
  - Pointer <= (g+1) mod NUM_MASTERS.
  - No eligible channel: msValid<=0 and the pointer is unchanged.
- Latency: 1 cycle from upTaken to msValid. Back-to-back transfers sustain 1 request/cycle.
- Outstanding counter i:
  - +1 when a read is accepted from channel i (at the upTaken cycle).
  - -1 on each dnValid[i] && dnTaken[i].
  - A simultaneous +1 and -1 leaves it unchanged. The counter never exceeds MAX_OUTSTANDING and never underflows; a response with count 0 is still delivered and the count stays 0.
- Response routing (combinational):
  - idx = smID - MASTER_ID_BASE.
  - If 0 <= idx < NUM_MASTERS: dnValid[idx]=smValid, dnData[idx]=smData, smTaken=dnTaken[idx].
  - All other dnValid bits are 0. dnData on every channel may be driven with smData.
  - Unknown ID: no dnValid is asserted and smTaken=1 (drop). dropCount increments on each such smValid cycle and saturates at 255.
- Requests and responses are independent and may transfer in the same cycle.

Test Plan:
- Single channel: ch1 read at 0x100 -> upTaken[1] in cycle 0; cycle 1 msValid=1, msID=6, msAddress=0x100, msWrite=0; held until msTaken.
- All 4 channels valid continuously, msTaken=1 -> grants in order 0,1,2,3,0,..., one per cycle, msID 5,6,7,8,5.
- Backpressure: msTaken=0 for 5 cycles with ch0 and ch2 valid -> msValid/payload stable, no upTaken asserted; the grant resumes at the pointer when taken.
- Outstanding cap (MAX_OUTSTANDING=4): ch3 issues 4 reads with no responses -> a 5th read is not granted and ch3 writes still are; one response smID=8 taken -> the 5th read is granted next.
- Response routing: smID=7, smData=0xABCDEF -> dnValid[2]=1, dnData[2]=0xABCDEF, smTaken follows dnTaken[2]; smID=2 -> smTaken=1, dropCount 0->1.
- Reset asserted mid-stream with msValid=1 -> next cycle msValid=0, dropCount=0, pointer restarts at channel 0.

Source files
------------

// File: rtl/memory_bus_arbiter_if.sv
// Bundle of the upstream ray-unit channels, the downstream memory master port
// and the response path shared by memory_bus_arbiter and its environment.
interface memory_bus_arbiter_if #(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8
);
  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] upAddress;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]    upData;
  logic [NUM_MASTERS-1:0]               upWrite;
  logic [NUM_MASTERS-1:0]               upValid;
  logic [NUM_MASTERS-1:0]               upTaken;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]    dnData;
  logic [NUM_MASTERS-1:0]               dnValid;
  logic [NUM_MASTERS-1:0]               dnTaken;
  logic [MASTER_ID_WIDTH-1:0]           msID;
  logic [ADDRESS_WIDTH-1:0]             msAddress;
  logic [DATA_WIDTH-1:0]                msData;
  logic                                 msWrite;
  logic                                 msValid;
  logic                                 msTaken;
  logic [MASTER_ID_WIDTH-1:0]           smID;
  logic [DATA_WIDTH-1:0]                smData;
  logic                                 smValid;
  logic                                 smTaken;
  logic [7:0]                           dropCount;

  // Every channel transfers on valid && taken in the same cycle; the source
  // keeps valid and payload stable until that cycle.
  modport slave (
    input  upAddress, upData, upWrite, upValid, dnTaken, msTaken,
    input  smID, smData, smValid,
    output upTaken, dnData, dnValid, msID, msAddress, msData, msWrite,
    output msValid, smTaken, dropCount
  );

  modport master (
    output upAddress, upData, upWrite, upValid, dnTaken, msTaken,
    output smID, smData, smValid,
    input  upTaken, dnData, dnValid, msID, msAddress, msData, msWrite,
    input  msValid, smTaken, dropCount
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin N-to-1 memory request arbiter with a per-channel read cap and
// smID-based response routing back to the issuing channel.
module memory_bus_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int MASTER_ID_BASE  = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clock,
  input logic reset,
  memory_bus_arbiter_if.slave bus
);
  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PW-1:0]              r_pointer;
  logic [3:0]                 r_outstanding [NUM_MASTERS];
  logic                       r_ms_valid;
  logic [MASTER_ID_WIDTH-1:0] r_ms_id;
  logic [ADDRESS_WIDTH-1:0]   r_ms_address;
  logic [DATA_WIDTH-1:0]      r_ms_data;
  logic                       r_ms_write;
  logic [7:0]                 r_drop_count;

  logic                   w_load;
  logic [NUM_MASTERS-1:0] w_eligible;
  logic                   w_found;
  logic [PW-1:0]          w_grant;
  logic [NUM_MASTERS-1:0] w_up_taken;
  int                     w_resp_idx;
  logic                   w_known;
  logic [PW-1:0]          w_resp_sel;
  logic [NUM_MASTERS-1:0] w_dn_valid;
  logic                   w_sm_taken;

  // Reset gates the load so no channel sees its request taken while the
  // output register is being cleared.
  assign w_load = !reset && (!r_ms_valid || bus.msTaken);

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      w_eligible[i] = bus.upValid[i] &&
                      (bus.upWrite[i] || (r_outstanding[i] < 4'(MAX_OUTSTANDING)));
  end

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_found && w_eligible[(int'(r_pointer) + k) % NUM_MASTERS]) begin
        w_found = 1'b1;
        w_grant = PW'((int'(r_pointer) + k) % NUM_MASTERS);
      end
    end
  end

  assign w_up_taken = (w_load && w_found) ? (NUM_MASTERS'(1) << w_grant) : '0;

  // Response routing: IDs outside the channel window are swallowed.
  always_comb begin
    w_resp_idx = int'(bus.smID) - MASTER_ID_BASE;
    w_known    = (w_resp_idx >= 0) && (w_resp_idx < NUM_MASTERS);
    w_resp_sel = PW'(w_resp_idx);
    w_dn_valid = '0;
    w_sm_taken = 1'b1;
    if (w_known) begin
      w_dn_valid[w_resp_sel] = bus.smValid;
      w_sm_taken             = bus.dnTaken[w_resp_sel];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pointer    <= '0;
      r_ms_valid   <= 1'b0;
      r_ms_id      <= '0;
      r_ms_address <= '0;
      r_ms_data    <= '0;
      r_ms_write   <= 1'b0;
      r_drop_count <= 8'd0;
      for (int i = 0; i < NUM_MASTERS; i++) r_outstanding[i] <= 4'd0;
    end else begin
      if (w_load) begin
        if (w_found) begin
          r_ms_valid   <= 1'b1;
          r_ms_id      <= MASTER_ID_WIDTH'(MASTER_ID_BASE + int'(w_grant));
          r_ms_address <= bus.upAddress[int'(w_grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          r_ms_data    <= bus.upData[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
          r_ms_write   <= bus.upWrite[w_grant];
          r_pointer    <= PW'((int'(w_grant) + 1) % NUM_MASTERS);
        end else begin
          r_ms_valid <= 1'b0;
        end
      end
      // Simultaneous issue and retire cancel; the count is clamped both ways.
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_up_taken[i] && !bus.upWrite[i] && !(w_dn_valid[i] && bus.dnTaken[i])) begin
          if (r_outstanding[i] < 4'(MAX_OUTSTANDING)) r_outstanding[i] <= r_outstanding[i] + 4'd1;
        end else if (!(w_up_taken[i] && !bus.upWrite[i]) && w_dn_valid[i] && bus.dnTaken[i]) begin
          if (r_outstanding[i] != 4'd0) r_outstanding[i] <= r_outstanding[i] - 4'd1;
        end
      end
      if (bus.smValid && !w_known && r_drop_count != 8'hFF)
        r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign bus.upTaken   = w_up_taken;
  assign bus.dnValid   = w_dn_valid;
  assign bus.dnData    = {NUM_MASTERS{bus.smData}};
  assign bus.smTaken   = w_sm_taken;
  assign bus.msValid   = r_ms_valid;
  assign bus.msID      = r_ms_id;
  assign bus.msAddress = r_ms_address;
  assign bus.msData    = r_ms_data;
  assign bus.msWrite   = r_ms_write;
  assign bus.dropCount = r_drop_count;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: grant order, backpressure, read cap,
// response routing and reset behaviour.
module tb_memory_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 24;
  localparam int AW = 32;
  localparam int IW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks   = 0;
  int failures = 0;

  memory_bus_arbiter_if #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                          .MASTER_ID_WIDTH(IW)) bus ();

  memory_bus_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                       .MASTER_ID_WIDTH(IW), .MASTER_ID_BASE(5), .MAX_OUTSTANDING(4))
    dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.upAddress = '0;
    bus.upData    = '0;
    bus.upWrite   = '0;
    bus.upValid   = '0;
    bus.dnTaken   = '0;
    bus.msTaken   = 1'b0;
    bus.smID      = '0;
    bus.smData    = '0;
    bus.smValid   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.msValid !== 1'b0) begin failures++; $display("FAIL reset_msValid got=%0h exp=0", bus.msValid); end
    checks++; if (bus.msID !== 8'd0) begin failures++; $display("FAIL reset_msID got=%0h exp=0", bus.msID); end
    checks++; if (bus.msAddress !== 32'd0) begin failures++; $display("FAIL reset_msAddress got=%0h exp=0", bus.msAddress); end
    checks++; if (bus.msData !== 24'd0 || bus.msWrite !== 1'b0) begin failures++; $display("FAIL reset_payload got=%0h/%0h exp=0/0", bus.msData, bus.msWrite); end
    checks++; if (bus.dropCount !== 8'd0) begin failures++; $display("FAIL reset_dropCount got=%0d exp=0", bus.dropCount); end
    checks++; if (bus.upTaken !== 4'b0000) begin failures++; $display("FAIL reset_upTaken got=%b exp=0000", bus.upTaken); end
  endtask

  task automatic test_single();
    do_reset();
    bus.upAddress[1*AW +: AW] = 32'h100;
    bus.upValid = 4'b0010;
    #1;
    checks++; if (bus.upTaken !== 4'b0010) begin failures++; $display("FAIL single_upTaken got=%b exp=0010", bus.upTaken); end
    tick();
    bus.upValid = 4'b0000;
    checks++; if (bus.msValid !== 1'b1) begin failures++; $display("FAIL single_msValid got=%0h exp=1", bus.msValid); end
    checks++; if (bus.msID !== 8'd6) begin failures++; $display("FAIL single_msID got=%0d exp=6", bus.msID); end
    checks++; if (bus.msAddress !== 32'h100 || bus.msWrite !== 1'b0) begin failures++; $display("FAIL single_payload got=%0h/%0h exp=100/0", bus.msAddress, bus.msWrite); end
    tick();
    tick();
    checks++; if (bus.msValid !== 1'b1 || bus.msID !== 8'd6 || bus.msAddress !== 32'h100) begin failures++; $display("FAIL single_hold got=%0h/%0d/%0h exp=1/6/100", bus.msValid, bus.msID, bus.msAddress); end
    bus.msTaken = 1'b1;
    tick();
    checks++; if (bus.msValid !== 1'b0) begin failures++; $display("FAIL single_release got=%0h exp=0", bus.msValid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.upAddress[i*AW +: AW] = 32'h1000 + 32'(i);
      bus.upData[i*DW +: DW]    = 24'h10 + 24'(i);
    end
    bus.upWrite = 4'b1111;
    bus.upValid = 4'b1111;
    bus.msTaken = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.upTaken !== (4'b0001 << (c % 4))) begin failures++; $display("FAIL rr_upTaken[%0d] got=%b exp=%b", c, bus.upTaken, 4'b0001 << (c % 4)); end
      tick();
      checks++; if (bus.msValid !== 1'b1 || bus.msID !== 8'(5 + c % 4)) begin failures++; $display("FAIL rr_msID[%0d] got=%0h/%0d exp=1/%0d", c, bus.msValid, bus.msID, 5 + c % 4); end
      checks++; if (bus.msAddress !== 32'h1000 + 32'(c % 4) || bus.msData !== 24'h10 + 24'(c % 4) || bus.msWrite !== 1'b1) begin failures++; $display("FAIL rr_payload[%0d] got=%0h/%0h/%0h", c, bus.msAddress, bus.msData, bus.msWrite); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.upAddress[0*AW +: AW] = 32'hA0;
    bus.upAddress[2*AW +: AW] = 32'hA2;
    bus.upValid = 4'b0101;
    #1;
    checks++; if (bus.upTaken !== 4'b0001) begin failures++; $display("FAIL bp_first got=%b exp=0001", bus.upTaken); end
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.upTaken !== 4'b0000) begin failures++; $display("FAIL bp_stall_upTaken[%0d] got=%b exp=0000", c, bus.upTaken); end
      checks++; if (bus.msValid !== 1'b1 || bus.msID !== 8'd5 || bus.msAddress !== 32'hA0) begin failures++; $display("FAIL bp_stall_hold[%0d] got=%0h/%0d/%0h exp=1/5/a0", c, bus.msValid, bus.msID, bus.msAddress); end
      tick();
    end
    bus.msTaken = 1'b1;
    #1;
    checks++; if (bus.upTaken !== 4'b0100) begin failures++; $display("FAIL bp_resume got=%b exp=0100", bus.upTaken); end
    tick();
    checks++; if (bus.msID !== 8'd7 || bus.msAddress !== 32'hA2) begin failures++; $display("FAIL bp_resume_payload got=%0d/%0h exp=7/a2", bus.msID, bus.msAddress); end
    checks++; if (bus.upTaken !== 4'b0001) begin failures++; $display("FAIL bp_wrap got=%b exp=0001", bus.upTaken); end
  endtask

  task automatic test_outstanding_cap();
    do_reset();
    bus.upAddress[3*AW +: AW] = 32'h300;
    bus.upValid = 4'b1000;
    bus.msTaken = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.upTaken !== 4'b1000) begin failures++; $display("FAIL cap_read[%0d] got=%b exp=1000", c, bus.upTaken); end
      tick();
    end
    checks++; if (bus.upTaken !== 4'b0000) begin failures++; $display("FAIL cap_blocked got=%b exp=0000", bus.upTaken); end
    bus.upWrite = 4'b1000;
    #1;
    checks++; if (bus.upTaken !== 4'b1000) begin failures++; $display("FAIL cap_write_ok got=%b exp=1000", bus.upTaken); end
    tick();
    checks++; if (bus.msWrite !== 1'b1 || bus.msID !== 8'd8) begin failures++; $display("FAIL cap_write_issue got=%0h/%0d exp=1/8", bus.msWrite, bus.msID); end
    bus.upWrite = 4'b0000;
    #1;
    checks++; if (bus.upTaken !== 4'b0000) begin failures++; $display("FAIL cap_still_blocked got=%b exp=0000", bus.upTaken); end
    bus.smID = 8'd8;
    bus.smData = 24'h123456;
    bus.smValid = 1'b1;
    bus.dnTaken = 4'b1000;
    #1;
    checks++; if (bus.dnValid !== 4'b1000 || bus.smTaken !== 1'b1) begin failures++; $display("FAIL cap_resp got=%b/%0h exp=1000/1", bus.dnValid, bus.smTaken); end
    tick();
    bus.smValid = 1'b0;
    bus.dnTaken = 4'b0000;
    #1;
    checks++; if (bus.upTaken !== 4'b1000) begin failures++; $display("FAIL cap_fifth got=%b exp=1000", bus.upTaken); end
    tick();
    bus.upValid = 4'b0000;
    checks++; if (bus.msValid !== 1'b1 || bus.msID !== 8'd8 || bus.msWrite !== 1'b0) begin failures++; $display("FAIL cap_fifth_issue got=%0h/%0d/%0h exp=1/8/0", bus.msValid, bus.msID, bus.msWrite); end
  endtask

  task automatic test_response_routing();
    do_reset();
    bus.smID = 8'd7;
    bus.smData = 24'hABCDEF;
    bus.smValid = 1'b1;
    #1;
    checks++; if (bus.dnValid !== 4'b0100) begin failures++; $display("FAIL route_dnValid got=%b exp=0100", bus.dnValid); end
    checks++; if (bus.dnData[2*DW +: DW] !== 24'hABCDEF) begin failures++; $display("FAIL route_dnData got=%0h exp=abcdef", bus.dnData[2*DW +: DW]); end
    checks++; if (bus.smTaken !== 1'b0) begin failures++; $display("FAIL route_smTaken_low got=%0h exp=0", bus.smTaken); end
    bus.dnTaken = 4'b0100;
    #1;
    checks++; if (bus.smTaken !== 1'b1) begin failures++; $display("FAIL route_smTaken_high got=%0h exp=1", bus.smTaken); end
    bus.dnTaken = 4'b1011;
    #1;
    checks++; if (bus.smTaken !== 1'b0) begin failures++; $display("FAIL route_smTaken_other got=%0h exp=0", bus.smTaken); end
    bus.dnTaken = 4'b0000;
    bus.smID = 8'd5;
    #1;
    checks++; if (bus.dnValid !== 4'b0001) begin failures++; $display("FAIL route_base got=%b exp=0001", bus.dnValid); end
    tick();
    checks++; if (bus.dropCount !== 8'd0) begin failures++; $display("FAIL route_no_drop got=%0d exp=0", bus.dropCount); end
    bus.smID = 8'd2;
    #1;
    checks++; if (bus.dnValid !== 4'b0000 || bus.smTaken !== 1'b1) begin failures++; $display("FAIL drop_low got=%b/%0h exp=0000/1", bus.dnValid, bus.smTaken); end
    tick();
    checks++; if (bus.dropCount !== 8'd1) begin failures++; $display("FAIL drop_count1 got=%0d exp=1", bus.dropCount); end
    bus.smID = 8'd9;
    #1;
    checks++; if (bus.dnValid !== 4'b0000 || bus.smTaken !== 1'b1) begin failures++; $display("FAIL drop_high got=%b/%0h exp=0000/1", bus.dnValid, bus.smTaken); end
    tick();
    bus.smValid = 1'b0;
    tick();
    checks++; if (bus.dropCount !== 8'd2) begin failures++; $display("FAIL drop_count2 got=%0d exp=2", bus.dropCount); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.upWrite = 4'b1111;
    bus.upValid = 4'b1111;
    bus.msTaken = 1'b1;
    bus.smID = 8'd2;
    bus.smValid = 1'b1;
    tick();
    bus.smValid = 1'b0;
    tick();
    checks++; if (bus.msValid !== 1'b1 || bus.msID !== 8'd6 || bus.dropCount !== 8'd1) begin failures++; $display("FAIL mid_pre got=%0h/%0d/%0d exp=1/6/1", bus.msValid, bus.msID, bus.dropCount); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.msValid !== 1'b0 || bus.dropCount !== 8'd0) begin failures++; $display("FAIL mid_reset got=%0h/%0d exp=0/0", bus.msValid, bus.dropCount); end
    checks++; if (bus.upTaken !== 4'b0001) begin failures++; $display("FAIL mid_pointer got=%b exp=0001", bus.upTaken); end
    tick();
    checks++; if (bus.msID !== 8'd5) begin failures++; $display("FAIL mid_first_id got=%0d exp=5", bus.msID); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_outstanding_cap();
    test_response_routing();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
